// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the GPU data-memory load/store path.
// Holds the read-responder state encoding and the default bus widths.
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    RELAY    = 2'b10
  } resp_state_e;

endpackage

// File: rtl/mem_read_responder_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i,
// wrapping past the top index back to zero.
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N_REQ-1:0]    req_i,
  input  logic [IDX_BITS-1:0] rr_ptr_i,
  output logic                grant_valid_o,
  output logic [IDX_BITS-1:0] grant_idx_o
);

  int idx;

  // Walk offsets from farthest to nearest so the closest hit to rr_ptr_i wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr_i) + off) % N_REQ;
      if (req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IDX_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_read_responder.sv
// Serves LSU load requests one at a time onto a single data-memory read channel,
// picking consumers round-robin and returning data with a one-cycle ready pulse.
//
// state    | meaning
// IDLE     | no request in flight; arbitrate among valid consumers
// MEM_WAIT | request issued to memory; holding address until mem_read_ready
// RELAY    | data delivered; wait for the served consumer to drop valid
module mem_read_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           busy
);

  localparam int ID_BITS = $clog2(NUM_CONSUMERS);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_CONSUMERS - 1);

  resp_state_e                       state_q, state_d;
  logic [ID_BITS-1:0]                rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]                id_q, id_d;
  logic [NUM_CONSUMERS-1:0]          ready_q, ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
  logic                              mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]              mem_addr_q, mem_addr_d;
  logic                              busy_q, busy_d;

  logic               grant_valid;
  logic [ID_BITS-1:0] grant_idx;

  rr_arbiter #(
    .N_REQ   (NUM_CONSUMERS),
    .IDX_BITS(ID_BITS)
  ) u_arb (
    .req_i        (consumer_read_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    ready_d     = '0;
    data_d      = data_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d        = grant_idx;
          mem_valid_d = 1'b1;
          mem_addr_d  = consumer_read_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
          state_d     = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_read_ready) begin
          mem_valid_d = 1'b0;
          data_d[int'(id_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
          ready_d[id_q] = 1'b1;
          state_d     = RELAY;
        end
      end
      RELAY: begin
        // Holding here until valid drops keeps a still-held request from being re-served.
        if (!consumer_read_valid[id_q]) begin
          rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign busy                = busy_q;

endmodule
